// File: rtl/onehot_pkg.sv
// Shared constants for the one-hot change monitor: word widths, the four legal
// one-hot patterns, and the saturation limit for the per-line hit counters.
package onehot_pkg;

    localparam int ONEHOT_W = 4;
    localparam int CODE_W   = 2;

    localparam logic [ONEHOT_W-1:0] OH_LINE0 = 4'b0001;
    localparam logic [ONEHOT_W-1:0] OH_LINE1 = 4'b0010;
    localparam logic [ONEHOT_W-1:0] OH_LINE2 = 4'b0100;
    localparam logic [ONEHOT_W-1:0] OH_LINE3 = 4'b1000;

    // Largest value a cw-bit hit counter may hold before it stops counting.
    function automatic int unsigned sat_max(input int unsigned cw);
        return (32'd1 << cw) - 32'd1;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder. Flags words that are zero or
// multi-hot; the code is 0 for those words and must be ignored by the caller.
module onehot_enc
    import onehot_pkg::*;
(
    input  logic [ONEHOT_W-1:0] word,
    output logic [CODE_W-1:0]   code,
    output logic                is_onehot
);

    // Map each legal pattern to its line index; everything else is illegal.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        code      = '0;
        is_onehot = 1'b0;
        case (word)
            OH_LINE0: begin code = 2'd0; is_onehot = 1'b1; end
            OH_LINE1: begin code = 2'd1; is_onehot = 1'b1; end
            OH_LINE2: begin code = 2'd2; is_onehot = 1'b1; end
            OH_LINE3: begin code = 2'd3; is_onehot = 1'b1; end
            default:  begin code = '0;   is_onehot = 1'b0; end
        endcase
    end

endmodule

// File: rtl/onehot_change_mon.sv
// Observation stage for a 2-to-4 decoder: registers the one-hot word, checks
// it, re-encodes it, strobes on value changes and counts hits per line.
module onehot_change_mon
    import onehot_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ONEHOT_W-1:0] y_in,
    input  logic                clr_cnt,
    input  logic [1:0]          cnt_sel,
    output logic [CODE_W-1:0]   code,
    output logic                valid,
    output logic                chg,
    output logic                err,
    output logic                err_stk,
    output logic [CW-1:0]       cnt_out
);

    localparam logic [CW-1:0] CNT_MAX = CW'(sat_max(CW));

    logic [ONEHOT_W-1:0] y_q;
    logic                first;
    logic [CODE_W-1:0]   enc_code;
    logic                enc_onehot;
    logic                chg_next;
    logic                cnt_inc;
    logic [CW-1:0]       cnt [ONEHOT_W];

    onehot_enc u_enc (
        .word      (y_in),
        .code      (enc_code),
        .is_onehot (enc_onehot)
    );

    // The first sample after reset always counts as a change, even for 0000.
    assign chg_next = first | (y_in != y_q);
    assign cnt_inc  = en & chg_next & enc_onehot;

    // Sample register, change strobe and one-hot check results.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            y_q     <= '0;
            first   <= 1'b1;
            code    <= '0;
            valid   <= 1'b0;
            chg     <= 1'b0;
            err     <= 1'b0;
            err_stk <= 1'b0;
        end else if (en) begin
            y_q   <= y_in;
            first <= 1'b0;
            chg   <= chg_next;
            if (enc_onehot) begin
                code  <= enc_code;
                valid <= 1'b1;
                err   <= 1'b0;
            end else begin
                valid   <= 1'b0;
                err     <= 1'b1;
                err_stk <= 1'b1;
            end
        end else begin
            chg <= 1'b0;
            err <= 1'b0;
        end
    end

    // Per-line saturating hit counters; clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        // NOTE: the counter array is reset explicitly; it is a handful of flops, not a RAM.
        if (rst || clr_cnt) begin
            for (int i = 0; i < ONEHOT_W; i++) cnt[i] <= '0;
        end else if (cnt_inc) begin
            for (int i = 0; i < ONEHOT_W; i++) begin
                if (enc_code == CODE_W'(i) && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign cnt_out = cnt[cnt_sel];

endmodule

// File: tb/tb_onehot_change_mon.sv
// Randomized and directed bench for onehot_change_mon. Two instances (CW=8 and
// CW=2) share the stimulus and are compared against a behavioural model.
module tb_onehot_change_mon;

    logic       clk = 1'b0;
    logic       rst, en, clr_cnt;
    logic [3:0] y_in;
    logic [1:0] cnt_sel;

    logic [1:0] code_a, code_b;
    logic       valid_a, valid_b, chg_a, chg_b, err_a, err_b, stk_a, stk_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    // Model state: shared sample behaviour plus per-instance counters.
    int m_yq;
    bit m_first;
    int m_code;
    bit m_valid, m_chg, m_err, m_stk;
    int m_cnt [2][4];
    int m_max [2] = '{255, 3};

    always #10 clk = ~clk;

    onehot_change_mon #(.CW(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr_cnt(clr_cnt),
        .cnt_sel(cnt_sel), .code(code_a), .valid(valid_a), .chg(chg_a),
        .err(err_a), .err_stk(stk_a), .cnt_out(cnt_a)
    );

    onehot_change_mon #(.CW(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .y_in(y_in), .clr_cnt(clr_cnt),
        .cnt_sel(cnt_sel), .code(code_b), .valid(valid_b), .chg(chg_b),
        .err(err_b), .err_stk(stk_b), .cnt_out(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, written from the rules directly.
    task automatic model_step(input bit r, input bit e, input bit c, input int y);
        int  ones;
        int  idx;
        bit  strobe;
        ones = 0;
        idx  = 0;
        for (int b = 0; b < 4; b++) begin
            if ((y >> b) & 1) begin
                ones++;
                idx = b;
            end
        end
        if (r) begin
            m_yq = 0; m_first = 1; m_code = 0;
            m_valid = 0; m_chg = 0; m_err = 0; m_stk = 0;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            return;
        end
        strobe = 0;
        if (e) begin
            strobe  = m_first || (y != m_yq);
            m_chg   = strobe;
            m_yq    = y;
            m_first = 0;
            if (ones == 1) begin
                m_valid = 1; m_err = 0; m_code = idx;
            end else begin
                m_valid = 0; m_err = 1; m_stk = 1;
            end
        end else begin
            m_chg = 0;
            m_err = 0;
        end
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            end else if (e && strobe && ones == 1 && m_cnt[k][idx] < m_max[k]) begin
                m_cnt[k][idx] = m_cnt[k][idx] + 1;
            end
        end
    endtask

    // Apply one cycle of stimulus, then compare every output of both instances.
    task automatic drive(input bit r, input bit e, input bit c, input logic [3:0] y);
        @(negedge clk);
        rst = r; en = e; clr_cnt = c; y_in = y;
        @(posedge clk);
        model_step(r, e, c, int'(y));
        #1;
        check("code_a",  32'(code_a),  32'(m_code));
        check("valid_a", 32'(valid_a), 32'(m_valid));
        check("chg_a",   32'(chg_a),   32'(m_chg));
        check("err_a",   32'(err_a),   32'(m_err));
        check("stk_a",   32'(stk_a),   32'(m_stk));
        check("code_b",  32'(code_b),  32'(m_code));
        check("valid_b", 32'(valid_b), 32'(m_valid));
        check("chg_b",   32'(chg_b),   32'(m_chg));
        check("err_b",   32'(err_b),   32'(m_err));
        check("stk_b",   32'(stk_b),   32'(m_stk));
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            check($sformatf("cnt_a[%0d]", i), 32'(cnt_a), 32'(m_cnt[0][i]));
            check($sformatf("cnt_b[%0d]", i), 32'(cnt_b), 32'(m_cnt[1][i]));
        end
    endtask

    initial begin
        logic [3:0] ry;
        rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; y_in = 4'b0000; cnt_sel = 2'd0;
        m_yq = 0; m_first = 1; m_code = 0;
        m_valid = 0; m_chg = 0; m_err = 0; m_stk = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;

        // Reset, then a held valid word: strobe only on the first sample.
        drive(1, 0, 0, 4'b0000);
        drive(1, 0, 0, 4'b0000);
        repeat (3) drive(0, 1, 0, 4'b0001);

        // Change sequence across several lines including a repeat.
        drive(0, 1, 0, 4'b0001);
        drive(0, 1, 0, 4'b0100);
        drive(0, 1, 0, 4'b0100);
        drive(0, 1, 0, 4'b1000);
        drive(0, 1, 0, 4'b0001);

        // Zero and multi-hot words, then recovery to a valid word.
        drive(0, 1, 0, 4'b0000);
        drive(0, 1, 0, 4'b0110);
        drive(0, 1, 0, 4'b0010);

        // Saturation of the narrow counters, then clear on a valid change.
        for (int i = 0; i < 10; i++) drive(0, 1, 0, (i % 2 == 0) ? 4'b0001 : 4'b0010);
        drive(0, 1, 1, 4'b0001);
        drive(0, 1, 0, 4'b0001);

        // Disabled sampling while the input moves, then re-enable.
        drive(0, 0, 0, 4'b0100);
        drive(0, 0, 0, 4'b0000);
        drive(0, 0, 0, 4'b1100);
        drive(0, 1, 0, 4'b1000);

        // Clear while disabled.
        drive(0, 0, 1, 4'b0010);

        // Reset mid-stream with a steady input.
        drive(0, 1, 0, 4'b0100);
        drive(0, 1, 0, 4'b0100);
        drive(1, 1, 0, 4'b0100);
        drive(0, 1, 0, 4'b0100);
        drive(0, 1, 0, 4'b0100);

        // Randomized traffic, mostly legal words with occasional faults.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) ry = 4'(1 << $urandom_range(0, 3));
            else                           ry = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 19) == 0,
                  ry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
